// File: rtl/vdp_bus_sync.sv
// vdp_bus_sync: synchronizes async CPU strobes/mode/data into the pixel clock and emits one-clock port ticks.
module vdp_bus_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_LOW     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       csw_n,
  input  logic       csr_n,
  input  logic       mode,
  input  logic [7:0] cpu_din,
  output logic       reg_wr_tick,
  output logic       reg_rd_tick,
  output logic       vram_wr_tick,
  output logic       vram_rd_tick,
  output logic [7:0] dout
);
  typedef enum logic [1:0] {WAIT_HI, IDLE, ARM, HELD} state_t;
  localparam int CW = $clog2(MIN_LOW + 1);
  localparam int FW = $clog2(SYNC_STAGES + 1);
  logic [SYNC_STAGES-1:0] sw_q, sr_q, md_q;
  logic [7:0] dd_q [SYNC_STAGES];
  logic [FW-1:0] fill_q;
  state_t w_st_q, w_st_d, r_st_q, r_st_d;
  logic [CW-1:0] w_cnt_q, w_cnt_d, r_cnt_q, r_cnt_d;
  logic w_md_q, r_md_q;
  logic [7:0] w_dat_q, dout_q;
  logic w_fire, r_fire, w_latch, r_latch;
  logic reg_wr_q, reg_rd_q, vram_wr_q, vram_rd_q;
  logic sw, sr, md, primed;
  logic [7:0] dd;
  assign sw = sw_q[SYNC_STAGES-1];
  assign sr = sr_q[SYNC_STAGES-1];
  assign md = md_q[SYNC_STAGES-1];
  assign dd = dd_q[SYNC_STAGES-1];
  // chain contents are reset placeholders until SYNC_STAGES real samples have shifted in
  assign primed = fill_q == FW'(SYNC_STAGES);
  always_comb begin
    w_st_d  = w_st_q;
    w_cnt_d = w_cnt_q;
    w_fire  = 1'b0;
    w_latch = 1'b0;
    case (w_st_q)
      WAIT_HI: w_st_d = (primed && sw) ? IDLE : WAIT_HI;
      IDLE: if (!sw) begin
        w_st_d  = ARM;
        w_cnt_d = CW'(1);
        w_latch = 1'b1;
      end
      ARM: if (sw) w_st_d = IDLE;
      else if (w_cnt_q == CW'(MIN_LOW)) begin
        w_st_d = HELD;
        w_fire = 1'b1;
      end else w_cnt_d = w_cnt_q + CW'(1);
      default: w_st_d = sw ? IDLE : HELD;
    endcase
  end
  always_comb begin
    r_st_d  = r_st_q;
    r_cnt_d = r_cnt_q;
    r_fire  = 1'b0;
    r_latch = 1'b0;
    case (r_st_q)
      WAIT_HI: r_st_d = (primed && sr) ? IDLE : WAIT_HI;
      IDLE: if (!sr) begin
        r_st_d  = ARM;
        r_cnt_d = CW'(1);
        r_latch = 1'b1;
      end
      ARM: if (sr) r_st_d = IDLE;
      else if (r_cnt_q == CW'(MIN_LOW)) begin
        r_st_d = HELD;
        r_fire = 1'b1;
      end else r_cnt_d = r_cnt_q + CW'(1);
      default: r_st_d = sr ? IDLE : HELD;
    endcase
    // simultaneous strobes: write wins, an unheld read is parked until its strobe rises
    if (!sw && !sr && r_st_q != HELD) begin
      r_st_d  = WAIT_HI;
      r_fire  = 1'b0;
      r_latch = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_q      <= '1;
      sr_q      <= '1;
      md_q      <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) dd_q[i] <= '0;
      fill_q    <= '0;
      w_st_q    <= WAIT_HI;
      r_st_q    <= WAIT_HI;
      w_cnt_q   <= '0;
      r_cnt_q   <= '0;
      w_md_q    <= 1'b0;
      r_md_q    <= 1'b0;
      w_dat_q   <= '0;
      dout_q    <= '0;
      reg_wr_q  <= 1'b0;
      reg_rd_q  <= 1'b0;
      vram_wr_q <= 1'b0;
      vram_rd_q <= 1'b0;
    end else begin
      sw_q      <= {sw_q[SYNC_STAGES-2:0], csw_n};
      sr_q      <= {sr_q[SYNC_STAGES-2:0], csr_n};
      md_q      <= {md_q[SYNC_STAGES-2:0], mode};
      dd_q[0]   <= cpu_din;
      for (int i = 1; i < SYNC_STAGES; i++) dd_q[i] <= dd_q[i-1];
      fill_q    <= primed ? fill_q : fill_q + FW'(1);
      w_st_q    <= w_st_d;
      r_st_q    <= r_st_d;
      w_cnt_q   <= w_cnt_d;
      r_cnt_q   <= r_cnt_d;
      w_md_q    <= w_latch ? md : w_md_q;
      w_dat_q   <= w_latch ? dd : w_dat_q;
      r_md_q    <= r_latch ? md : r_md_q;
      dout_q    <= w_fire ? w_dat_q : dout_q;
      reg_wr_q  <= w_fire && w_md_q;
      vram_wr_q <= w_fire && !w_md_q;
      reg_rd_q  <= r_fire && r_md_q;
      vram_rd_q <= r_fire && !r_md_q;
    end
  end
  assign reg_wr_tick  = reg_wr_q;
  assign reg_rd_tick  = reg_rd_q;
  assign vram_wr_tick = vram_wr_q;
  assign vram_rd_tick = vram_rd_q;
  assign dout         = dout_q;
endmodule

// File: tb/tb_vdp_bus_sync.sv
// tb_vdp_bus_sync: directed strobe sequences with a queued scoreboard checked by a tick monitor.
module tb_vdp_bus_sync;
  logic clk = 1'b0, reset = 1'b1, csw_n = 1'b1, csr_n = 1'b1, mode = 1'b0;
  logic [7:0] cpu_din = 8'h00;
  logic reg_wr_tick, reg_rd_tick, vram_wr_tick, vram_rd_tick;
  logic [7:0] dout;
  typedef struct {int kind; logic [7:0] d; int cyc;} exp_t;
  exp_t sb[$];
  int checks = 0, failures = 0, cyc = 0;
  logic [7:0] exp_dout = 8'h00;
  vdp_bus_sync dut (
    .clk(clk), .reset(reset), .csw_n(csw_n), .csr_n(csr_n), .mode(mode), .cpu_din(cpu_din),
    .reg_wr_tick(reg_wr_tick), .reg_rd_tick(reg_rd_tick),
    .vram_wr_tick(vram_wr_tick), .vram_rd_tick(vram_rd_tick), .dout(dout)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // ticks in bit order: reg_wr, reg_rd, vram_wr, vram_rd
  always @(negedge clk) begin
    logic [3:0] t;
    exp_t e;
    t = {vram_rd_tick, vram_wr_tick, reg_rd_tick, reg_wr_tick};
    if (t != 4'b0) begin
      chk("onehot", $countones(t), 1);
      if (sb.size() == 0) chk("unexpected_tick", int'(t), 0);
      else begin
        e = sb.pop_front();
        chk("tick_kind", int'(t), 1 << e.kind);
        chk("tick_dout", int'(dout), int'(e.d));
        chk("tick_cycle", cyc, e.cyc);
      end
    end
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic expect_tick(input bit w, input bit m, input logic [7:0] d);
    if (w) exp_dout = d;
    sb.push_back('{w ? (m ? 0 : 2) : (m ? 1 : 3), exp_dout, cyc + 5});
  endtask
  task automatic pulse(input bit w, input bit r, input bit m, input logic [7:0] d,
                       input int nlow, input bit tick, input int gap);
    mode = m;
    cpu_din = d;
    csw_n = !w;
    csr_n = !r;
    if (tick) expect_tick(w, m, d);
    step(nlow);
    csw_n = 1'b1;
    csr_n = 1'b1;
    step(gap);
  endtask
  initial begin
    step(3);
    chk("reset_ticks", int'({reg_wr_tick, reg_rd_tick, vram_wr_tick, vram_rd_tick}), 0);
    chk("reset_dout", int'(dout), 0);
    reset = 1'b0;
    step(4);
    pulse(1, 0, 1, 8'hEE, 6, 1, 6);
    pulse(1, 0, 1, 8'h80, 6, 1, 6);
    pulse(1, 0, 1, 8'h11, 1, 0, 6);
    chk("glitch_dout", int'(dout), 8'h80);
    pulse(1, 0, 0, 8'h5A, 40, 1, 2);
    pulse(1, 0, 0, 8'hA5, 4, 1, 6);
    pulse(0, 1, 1, 8'h77, 5, 1, 6);
    pulse(0, 1, 0, 8'h66, 5, 1, 6);
    chk("read_dout", int'(dout), 8'hA5);
    pulse(1, 1, 1, 8'hC3, 6, 1, 6);
    mode = 1'b0;
    cpu_din = 8'h33;
    csw_n = 1'b0;
    expect_tick(1, 0, 8'h33);
    step(3);
    cpu_din = 8'hFF;
    mode = 1'b1;
    step(3);
    csw_n = 1'b1;
    step(6);
    chk("skew_dout", int'(dout), 8'h33);
    csw_n = 1'b0;
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    exp_dout = 8'h00;
    chk("reset2_dout", int'(dout), 0);
    step(10);
    csw_n = 1'b1;
    step(6);
    pulse(1, 0, 1, 8'h42, 4, 1, 6);
    mode = 1'b1;
    cpu_din = 8'h99;
    csw_n = 1'b0;
    step(3);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    csw_n = 1'b1;
    exp_dout = 8'h00;
    step(8);
    chk("arm_reset_dout", int'(dout), 0);
    pulse(0, 1, 0, 8'h12, 5, 1, 10);
    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
